// File: rtl/sram_zeroize_pkg.sv
// rtl/sram_zeroize_pkg.sv - shared types, TL-UL structs and integrity helper for the SRAM zeroizer
package sram_zeroize_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam logic [2:0] PutFullData   = 3'h0;
  localparam logic [2:0] AccessAck     = 3'h0;
  localparam logic [2:0] AccessAckData = 3'h1;
  localparam logic [1:0] PutSize       = 2'd2;
  localparam logic [3:0] PutMask       = 4'hF;
  localparam logic [3:0] InstrTypeData = 4'h9;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Linear 7-bit check code over a 57-bit word; the SRAM-side checker uses the same masks.
  function automatic logic [6:0] intg_ecc(input logic [56:0] d);
    logic [6:0] c;
    c[0] = ^(d & 57'h0_AD5B_56AA_D5B5_6A);
    c[1] = ^(d & 57'h1_366D_9B36_6D9B_36);
    c[2] = ^(d & 57'h0_C78F_1E3C_78F1_E3);
    c[3] = ^(d & 57'h1_F80F_E03F_80FE_03);
    c[4] = ^(d & 57'h0_07FF_003F_FF00_0F);
    c[5] = ^(d & 57'h1_FFFF_0000_00FF_FF);
    c[6] = ^(d & 57'h0_0000_FFFF_FFFF_FF);
    return c;
  endfunction

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// rtl/tlul_cmd_intg_gen.sv - command and data integrity generator for the TL-UL A channel
module tlul_cmd_intg_gen
  import sram_zeroize_pkg::*;
(
  input  logic [31:0] address,
  input  logic [2:0]  opcode,
  input  logic [3:0]  mask,
  input  logic [31:0] data,
  input  logic [3:0]  instr_type,
  output logic [6:0]  cmd_intg,
  output logic [6:0]  data_intg
);

  logic [56:0] cmd_word;
  logic [56:0] data_word;

  assign cmd_word  = {14'h0, instr_type, address, opcode, mask};
  assign data_word = {25'h0, data};

  assign cmd_intg  = intg_ecc(cmd_word);
  assign data_intg = intg_ecc(data_word);

endmodule

// File: rtl/sram_zeroize.sv
// rtl/sram_zeroize.sv - TL-UL host that fills the whole SRAM with a pattern and reports done/error
module sram_zeroize
  import sram_zeroize_pkg::*;
#(
  parameter int unsigned MemSize        = 64 * 1024,
  parameter logic [31:0] BaseAddr       = 32'h0,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] pattern_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output tl_h2d_t     tl_h2d_o,
  input  tl_d2h_t     tl_d2h_i
);

  localparam int unsigned Depth = MemSize / 4;
  localparam int unsigned IdxW  = $clog2(Depth) + 1;
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);
  localparam logic [OutW-1:0] MaxOut  = OutW'(MaxOutstanding);

  state_e          state;
  logic [IdxW-1:0] word_idx;
  logic [OutW-1:0] outstanding;
  logic [OutW-1:0] out_next;
  logic [31:0]     pattern_q;

  logic        in_fill;
  logic        a_valid;
  logic        a_fire;
  logic        rsp_seen;
  logic        rsp_bad;
  logic [31:0] a_address;
  logic [1:0]  src_lo;
  logic [6:0]  cmd_intg;
  logic [6:0]  data_intg;

  // Responses outside a fill belong to a transaction killed by reset and are dropped.
  assign in_fill  = (state == ISSUE) || (state == DRAIN);
  assign a_valid  = (state == ISSUE) && (outstanding < MaxOut);
  assign a_fire   = a_valid && tl_d2h_i.a_ready;
  assign rsp_seen = in_fill && tl_d2h_i.d_valid;
  assign rsp_bad  = tl_d2h_i.d_error || (tl_d2h_i.d_opcode != AccessAck) ||
                    (outstanding == '0);

  always_comb begin
    out_next = outstanding;
    unique case ({a_fire, rsp_seen})
      2'b10:   out_next = outstanding + 1'b1;
      2'b01:   if (outstanding != '0) out_next = outstanding - 1'b1;
      2'b11:   if (outstanding == '0) out_next = OutW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      word_idx    <= '0;
      outstanding <= '0;
      pattern_q   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      done_o      <= 1'b0;
      outstanding <= out_next;
      if (a_fire) word_idx <= word_idx + 1'b1;
      if (rsp_seen && rsp_bad) err_o <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state       <= ISSUE;
            busy_o      <= 1'b1;
            err_o       <= 1'b0;
            pattern_q   <= pattern_i;
            word_idx    <= '0;
            outstanding <= '0;
          end
        end
        ISSUE: begin
          if (a_fire && (word_idx == LastIdx)) state <= DRAIN;
        end
        DRAIN: begin
          if (out_next == '0) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign a_address = BaseAddr + (32'(word_idx) << 2);
  assign src_lo    = 2'(word_idx);

  tlul_cmd_intg_gen u_intg_gen (
    .address    (a_address),
    .opcode     (PutFullData),
    .mask       (PutMask),
    .data       (pattern_q),
    .instr_type (InstrTypeData),
    .cmd_intg   (cmd_intg),
    .data_intg  (data_intg)
  );

  always_comb begin
    tl_h2d_o                   = '0;
    tl_h2d_o.a_valid           = a_valid;
    tl_h2d_o.a_opcode          = PutFullData;
    tl_h2d_o.a_size            = PutSize;
    tl_h2d_o.a_source          = {6'h0, src_lo};
    tl_h2d_o.a_address         = a_address;
    tl_h2d_o.a_mask            = PutMask;
    tl_h2d_o.a_data            = pattern_q;
    tl_h2d_o.a_user.instr_type = InstrTypeData;
    tl_h2d_o.a_user.cmd_intg   = cmd_intg;
    tl_h2d_o.a_user.data_intg  = data_intg;
    tl_h2d_o.d_ready           = 1'b1;
  end

  logic unused_rsp;
  assign unused_rsp = ^{tl_d2h_i.d_param, tl_d2h_i.d_size, tl_d2h_i.d_source,
                        tl_d2h_i.d_sink, tl_d2h_i.d_data, tl_d2h_i.d_user};

endmodule

// File: tb/tb_sram_zeroize.sv
// tb/tb_sram_zeroize.sv - directed bench: SRAM port-b responder model and fill checks
module tb_sram_zeroize;
  import sram_zeroize_pkg::*;

  localparam int Words = 16;

  typedef struct {
    int due;
    int idx;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pattern;
  logic        busy;
  logic        done;
  logic        err;
  tl_h2d_t     h2d;
  tl_d2h_t     d2h;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [Words];
  pend_t       pend [$];
  int cyc = 0, acc_cnt, resp_cnt, done_cnt, max_inflight, hold_bad, req_bad;
  int busy_cyc, done_cyc, last_resp_cyc, lat, err_word, err_kind, timed_out;
  bit rand_ready, hold_chk, prev_busy;
  logic [31:0] hold_addr, hold_data;

  sram_zeroize #(
    .MemSize        (64),
    .BaseAddr       (32'h0),
    .MaxOutstanding (2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .pattern_i (pattern),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .tl_h2d_o  (h2d),
    .tl_d2h_i  (d2h)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock of the SRAM model, evaluated mid-cycle.
  task automatic step();
    pend_t p;
    int idx, inflight;
    @(negedge clk);
    cyc++;
    inflight = acc_cnt - resp_cnt;
    if (inflight > max_inflight) max_inflight = inflight;
    d2h.d_valid  = 1'b0;
    d2h.d_error  = 1'b0;
    d2h.d_opcode = AccessAck;
    d2h.d_source = 8'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      d2h.d_valid  = 1'b1;
      d2h.d_source = 8'(p.idx % 4);
      if (p.idx == err_word) begin
        if (err_kind == 1) d2h.d_error = 1'b1;
        else d2h.d_opcode = AccessAckData;
      end
      resp_cnt++;
      last_resp_cyc = cyc;
    end
    d2h.a_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (hold_chk && !(h2d.a_valid && h2d.a_address == hold_addr && h2d.a_data == hold_data))
      hold_bad++;
    hold_chk  = h2d.a_valid && !d2h.a_ready;
    hold_addr = h2d.a_address;
    hold_data = h2d.a_data;
    if (h2d.a_valid && d2h.a_ready) begin
      idx = int'(h2d.a_address >> 2);
      if (h2d.a_opcode != PutFullData || h2d.a_size != 2'd2 || h2d.a_mask != 4'hF ||
          h2d.a_address[1:0] != 2'b00 || idx >= Words || h2d.a_source != 8'(idx % 4) ||
          h2d.a_address != 32'(acc_cnt * 4) || !h2d.d_ready)
        req_bad++;
      else
        mem[idx] = h2d.a_data;
      pend.push_back('{due: cyc + lat, idx: idx});
      acc_cnt++;
    end
    if (busy && !prev_busy) busy_cyc = cyc;
    prev_busy = busy;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) req_bad++;
    end
  endtask

  task automatic run_fill(input logic [31:0] pat, input int restart_at, input int reset_at);
    int  n;
    bit  restarted;
    step();
    acc_cnt = 0; resp_cnt = 0; done_cnt = 0; max_inflight = 0;
    hold_bad = 0; req_bad = 0; hold_chk = 0;
    busy_cyc = -100; done_cyc = -100; last_resp_cyc = -100; timed_out = 0;
    for (int i = 0; i < Words; i++) mem[i] = 32'hDEAD_BEEF;
    start   = 1'b1;
    pattern = pat;
    n = 0;
    restarted = 0;
    while (done_cnt == 0 && n < 400) begin
      step();
      start = 1'b0;
      n++;
      if (acc_cnt == restart_at && !restarted) begin
        start     = 1'b1;
        pattern   = 32'hFFFF_FFFF;
        restarted = 1;
      end
      if (acc_cnt == reset_at) begin
        rst_n = 1'b0;
        #1;
        expect_eq("rst_busy", 32'(busy), 0);
        expect_eq("rst_avalid", 32'(h2d.a_valid), 0);
        pend.delete();
        resp_cnt = acc_cnt;
        hold_chk = 0;
        repeat (3) step();
        expect_eq("rst_no_done", done_cnt, 0);
        expect_eq("rst_held_idle", 32'(busy), 0);
        rst_n = 1'b1;
        return;
      end
    end
    if (n >= 400) timed_out = 1;
    expect_eq("timeout", timed_out, 0);
  endtask

  task automatic check_run(input logic [31:0] pat, input logic exp_err, input bit timing);
    expect_eq("done_cnt", done_cnt, 1);
    expect_eq("acc_cnt", acc_cnt, Words);
    expect_eq("resp_cnt", resp_cnt, Words);
    expect_eq("req_bad", req_bad, 0);
    expect_eq("hold_bad", hold_bad, 0);
    expect_eq("inflight_le2", 32'(max_inflight <= 2), 1);
    expect_eq("done_after_ack", done_cyc - last_resp_cyc, 1);
    expect_eq("err", 32'(err), 32'(exp_err));
    if (timing) expect_eq("busy_to_done", done_cyc - busy_cyc, 17);
    for (int i = 0; i < Words; i++) expect_eq($sformatf("mem%0d", i), mem[i], pat);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pattern = 32'h0;
    d2h = '0; d2h.a_ready = 1'b1;
    lat = 1; rand_ready = 0; err_word = -1; err_kind = 1;
    acc_cnt = 0; resp_cnt = 0; done_cnt = 0; prev_busy = 0; hold_chk = 0;
    repeat (3) step();
    expect_eq("reset_busy", 32'(busy), 0);
    expect_eq("reset_done", 32'(done), 0);
    expect_eq("reset_err", 32'(err), 0);
    expect_eq("reset_avalid", 32'(h2d.a_valid), 0);
    expect_eq("reset_dready", 32'(h2d.d_ready), 1);
    rst_n = 1'b1;
    step();

    run_fill(32'hA5A5_A5A5, -1, -1);
    check_run(32'hA5A5_A5A5, 1'b0, 1'b1);

    // start during the DONE cycle must not relaunch
    start = 1'b1; pattern = 32'h1111_1111;
    step();
    start = 1'b0;
    expect_eq("done_start_ignored", 32'(busy), 0);

    err_word = 5; err_kind = 1;
    run_fill(32'hC3C3_3C3C, -1, -1);
    check_run(32'hC3C3_3C3C, 1'b1, 1'b1);
    repeat (2) step();
    expect_eq("err_sticky", 32'(err), 1);
    err_word = -1;
    run_fill(32'h0000_0000, -1, -1);
    check_run(32'h0000_0000, 1'b0, 1'b1);

    err_word = 12; err_kind = 2;
    run_fill(32'h3C3C_C3C3, -1, -1);
    check_run(32'h3C3C_C3C3, 1'b1, 1'b1);
    err_word = -1;

    run_fill(32'h1234_5678, 7, -1);
    check_run(32'h1234_5678, 1'b0, 1'b1);

    run_fill(32'hFFFF_0000, -1, 9);
    run_fill(32'h5A5A_0F0F, -1, -1);
    check_run(32'h5A5A_0F0F, 1'b0, 1'b1);

    rand_ready = 1;
    run_fill(32'h0F0F_F0F0, -1, -1);
    check_run(32'h0F0F_F0F0, 1'b0, 1'b0);
    rand_ready = 0;

    lat = 3;
    run_fill(32'h9696_6969, -1, -1);
    check_run(32'h9696_6969, 1'b0, 1'b0);
    expect_eq("lat3_max_inflight", max_inflight, 2);
    lat = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
